// File: rtl/pipe_mult_delay_if.sv
// +----------------------------------------------------------------------------+
// | Module      : pipe_mult_delay_if                                           |
// | Description : Operand/product bundle for pipe_mult_delay. The master side  |
// |               drives operands, enable and valid; the slave side (the       |
// |               multiplier) returns the product and its valid.               |
// |               Carries the bypass select when PIPE_MULT_DELAY_BYPASS_EN is  |
// |               defined.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pipe_mult_delay_if #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16
);
  logic                       en;
  logic                       in_valid;
  logic [A_WIDTH-1:0]         a;
  logic [B_WIDTH-1:0]         b;
  logic [A_WIDTH+B_WIDTH-1:0] p;
  logic                       out_valid;
`ifdef PIPE_MULT_DELAY_BYPASS_EN
  logic                       bypass;

  modport master (output en, in_valid, a, b, bypass, input p, out_valid);
  modport slave  (input en, in_valid, a, b, bypass, output p, out_valid);
`else
  modport master (output en, in_valid, a, b, input p, out_valid);
  modport slave  (input en, in_valid, a, b, output p, out_valid);
`endif
endinterface

`default_nettype wire

// File: rtl/pipe_mult_delay.sv
// +----------------------------------------------------------------------------+
// | Module      : pipe_mult_delay                                              |
// | Description : Fully pipelined multiplier (signed or unsigned) with a       |
// |               matching valid pipeline. The multiply sits in stage 0; the   |
// |               remaining LATENCY-1 stages are plain output registers so     |
// |               synthesis can retime them into DSP pipeline registers.       |
// |               With LATENCY=1 it doubles as a one-cycle data/enable delay.  |
// |               Optional macro PIPE_MULT_DELAY_BYPASS_EN adds a bypass       |
// |               select that loads the extended operand a instead of a*b.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_mult_delay #(
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int LATENCY = 2,   // legal range 1..8
  parameter int SIGNED  = 1
) (
  input wire                 clk,
  input wire                 rst,
  pipe_mult_delay_if.slave   bus
);

  localparam int c_P_WIDTH = A_WIDTH + B_WIDTH;

  logic [c_P_WIDTH-1:0] w_a_ext;
  logic [c_P_WIDTH-1:0] w_b_ext;
  logic [c_P_WIDTH-1:0] w_prod;
  logic [c_P_WIDTH-1:0] w_stage0;

  logic [c_P_WIDTH-1:0] r_p [LATENCY];
  logic [LATENCY-1:0]   r_v;

  // Extend both operands to full product width. The low c_P_WIDTH bits of
  // the extended multiply equal the exact product for either signedness.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_a_ext = {{B_WIDTH{bus.a[A_WIDTH-1]}}, bus.a};
      assign w_b_ext = {{A_WIDTH{bus.b[B_WIDTH-1]}}, bus.b};
    end else begin : g_unsigned
      assign w_a_ext = {{B_WIDTH{1'b0}}, bus.a};
      assign w_b_ext = {{A_WIDTH{1'b0}}, bus.b};
    end
  endgenerate

  assign w_prod = w_a_ext * w_b_ext;

`ifdef PIPE_MULT_DELAY_BYPASS_EN
  // Bypass turns the block into a pure delay line for operand a.
  assign w_stage0 = bus.bypass ? w_a_ext : w_prod;
`else
  assign w_stage0 = w_prod;
`endif

  // Product and valid pipelines advance together on en; reset beats en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_p[i] <= '0;
      end
      r_v <= '0;
    end else if (bus.en) begin
      r_p[0] <= w_stage0;
      r_v[0] <= bus.in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_p[i] <= r_p[i-1];
        r_v[i] <= r_v[i-1];
      end
    end
  end

  assign bus.p         = r_p[LATENCY-1];
  assign bus.out_valid = r_v[LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_pipe_mult_delay.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_mult_delay                                           |
// | Description : Directed self-checking bench for pipe_mult_delay. Four      |
// |               instances: 16x16 signed L=2, 24x24 signed L=2, 16x16 signed  |
// |               L=1 and 16x16 unsigned L=2.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_mult_delay;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  pipe_mult_delay_if #(.A_WIDTH(16), .B_WIDTH(16)) if16 ();
  pipe_mult_delay_if #(.A_WIDTH(24), .B_WIDTH(24)) if24 ();
  pipe_mult_delay_if #(.A_WIDTH(16), .B_WIDTH(16)) if1  ();
  pipe_mult_delay_if #(.A_WIDTH(16), .B_WIDTH(16)) ifu  ();

  pipe_mult_delay #(.A_WIDTH(16), .B_WIDTH(16), .LATENCY(2), .SIGNED(1)) u_m16 (
    .clk(clk), .rst(rst), .bus(if16));
  pipe_mult_delay #(.A_WIDTH(24), .B_WIDTH(24), .LATENCY(2), .SIGNED(1)) u_m24 (
    .clk(clk), .rst(rst), .bus(if24));
  pipe_mult_delay #(.A_WIDTH(16), .B_WIDTH(16), .LATENCY(1), .SIGNED(1)) u_d1 (
    .clk(clk), .rst(rst), .bus(if1));
  pipe_mult_delay #(.A_WIDTH(16), .B_WIDTH(16), .LATENCY(2), .SIGNED(0)) u_mu (
    .clk(clk), .rst(rst), .bus(ifu));

  always #5 clk = ~clk;

  // Advance one rising edge, then settle just past it for drive and sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if16.en = 1'b1; if16.in_valid = 1'b1; if16.a = 16'h0005; if16.b = 16'h0007;
    if24.en = 1'b1; if24.in_valid = 1'b1; if24.a = 24'h000005; if24.b = 24'h000007;
    if1.en  = 1'b1; if1.in_valid  = 1'b1; if1.a  = 16'h0005; if1.b  = 16'h0007;
    ifu.en  = 1'b1; ifu.in_valid  = 1'b1; ifu.a  = 16'h0005; ifu.b  = 16'h0007;
    tick();
    tick();
    n_cmp++;
    if (if16.p !== 32'h0 || if16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_m16: got p=%h v=%b want p=0 v=0", if16.p, if16.out_valid);
    end
    n_cmp++;
    if (if24.p !== 48'h0 || if24.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_m24: got p=%h v=%b want p=0 v=0", if24.p, if24.out_valid);
    end
    n_cmp++;
    if (if1.p !== 32'h0 || if1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_d1: got p=%h v=%b want p=0 v=0", if1.p, if1.out_valid);
    end
    n_cmp++;
    if (ifu.p !== 32'h0 || ifu.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mu: got p=%h v=%b want p=0 v=0", ifu.p, ifu.out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    if16.a = 16'd3; if16.b = 16'hFFFC; if16.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (if16.p !== 32'h0 || if16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_edge1: got p=%h v=%b want p=0 v=0", if16.p, if16.out_valid);
    end
    if16.a = 16'd0; if16.b = 16'd0; if16.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (if16.p !== 32'hFFFFFFF4 || if16.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_edge2: got p=%h v=%b want p=fffffff4 v=1", if16.p, if16.out_valid);
    end
  endtask

  task automatic test_corners();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic [31:0] ve [6];
    va[0] = 16'h8000; vb[0] = 16'h8000; ve[0] = 32'h40000000;
    va[1] = 16'h7FFF; vb[1] = 16'h8000; ve[1] = 32'hC0008000;
    va[2] = 16'h0000; vb[2] = 16'h1234; ve[2] = 32'h00000000;
    va[3] = 16'hFFFF; vb[3] = 16'hFFFF; ve[3] = 32'h00000001;
    va[4] = 16'hFFFF; vb[4] = 16'h0001; ve[4] = 32'hFFFFFFFF;
    va[5] = 16'h7FFF; vb[5] = 16'h7FFF; ve[5] = 32'h3FFF0001;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        if16.a = va[i]; if16.b = vb[i]; if16.in_valid = 1'b1;
      end else begin
        if16.a = 16'd0; if16.b = 16'd0; if16.in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (if16.p !== ve[i-1] || if16.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL corners[%0d]: got p=%h v=%b want p=%h v=1",
                   i-1, if16.p, if16.out_valid, ve[i-1]);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [23:0] va [4];
    logic [23:0] vb [4];
    logic [47:0] ve [4];
    va[0] = 24'h7FFFFF; vb[0] = 24'h7FFFFF; ve[0] = 48'h3FFFFF000001;
    va[1] = 24'h800000; vb[1] = 24'h800000; ve[1] = 48'h400000000000;
    va[2] = 24'h000002; vb[2] = 24'hFFFFFD; ve[2] = 48'hFFFFFFFFFFFA;
    va[3] = 24'h800000; vb[3] = 24'h7FFFFF; ve[3] = 48'hC00000800000;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        if24.a = va[i]; if24.b = vb[i]; if24.in_valid = 1'b1;
      end else begin
        if24.a = 24'd0; if24.b = 24'd0; if24.in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        n_cmp++;
        if (if24.p !== ve[i-1] || if24.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL wide[%0d]: got p=%h v=%b want p=%h v=1",
                   i-1, if24.p, if24.out_valid, ve[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    if16.en = 1'b1; if16.a = 16'd100; if16.b = 16'd3; if16.in_valid = 1'b1;
    tick();
    if16.a = 16'd200; if16.b = 16'd3; if16.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (if16.p !== 32'd300 || if16.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got p=%h v=%b want p=%h v=1", if16.p, if16.out_valid, 32'd300);
    end
    rst = 1'b1; if16.en = 1'b0; if16.a = 16'd50; if16.b = 16'd2; if16.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (if16.p !== 32'd0 || if16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_clear: got p=%h v=%b want p=0 v=0", if16.p, if16.out_valid);
    end
    rst = 1'b0; if16.en = 1'b1; if16.a = 16'd0; if16.b = 16'd0; if16.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (if16.p !== 32'd0 || if16.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_after[%0d]: got p=%h v=%b want p=0 v=0", k, if16.p, if16.out_valid);
      end
    end
  endtask

  task automatic test_stall();
    if16.en = 1'b1; if16.a = 16'd5; if16.b = 16'd6; if16.in_valid = 1'b1;
    tick();
    if16.a = 16'd7; if16.b = 16'd8; if16.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (if16.p !== 32'd30 || if16.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_first: got p=%h v=%b want p=%h v=1", if16.p, if16.out_valid, 32'd30);
    end
    if16.en = 1'b0; if16.a = 16'd9; if16.b = 16'd9; if16.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (if16.p !== 32'd30 || if16.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got p=%h v=%b want p=%h v=1", k, if16.p, if16.out_valid, 32'd30);
      end
    end
    if16.en = 1'b1; if16.a = 16'd0; if16.b = 16'd0; if16.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (if16.p !== 32'd56 || if16.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_resume: got p=%h v=%b want p=%h v=1", if16.p, if16.out_valid, 32'd56);
    end
    tick();
    n_cmp++;
    if (if16.p !== 32'd0 || if16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: got p=%h v=%b want p=0 v=0", if16.p, if16.out_valid);
    end
  endtask

  task automatic test_latency1();
    if1.en = 1'b1; if1.a = 16'h1234; if1.b = 16'h0001; if1.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (if1.p !== 32'h00001234 || if1.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lat1_delay: got p=%h v=%b want p=00001234 v=1", if1.p, if1.out_valid);
    end
    if1.a = 16'hFFFE; if1.b = 16'h0001; if1.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (if1.p !== 32'hFFFFFFFE || if1.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat1_neg: got p=%h v=%b want p=fffffffe v=0", if1.p, if1.out_valid);
    end
    if1.a = 16'h7FFF; if1.b = 16'h7FFF; if1.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (if1.p !== 32'h3FFF0001 || if1.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL lat1_mul: got p=%h v=%b want p=3fff0001 v=1", if1.p, if1.out_valid);
    end
  endtask

  task automatic test_unsigned();
    ifu.en = 1'b1; ifu.a = 16'hFFFF; ifu.b = 16'hFFFF; ifu.in_valid = 1'b1;
    tick();
    ifu.a = 16'h8000; ifu.b = 16'h0002; ifu.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (ifu.p !== 32'hFFFE0001 || ifu.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL unsigned_max: got p=%h v=%b want p=fffe0001 v=1", ifu.p, ifu.out_valid);
    end
    ifu.a = 16'd0; ifu.b = 16'd0; ifu.in_valid = 1'b0;
    tick();
    n_cmp++;
    if (ifu.p !== 32'h00010000 || ifu.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL unsigned_msb: got p=%h v=%b want p=00010000 v=1", ifu.p, ifu.out_valid);
    end
  endtask

`ifdef PIPE_MULT_DELAY_BYPASS_EN
  task automatic test_bypass();
    if1.en = 1'b1; if1.bypass = 1'b1; if1.a = 16'h1234; if1.b = 16'h5555; if1.in_valid = 1'b1;
    tick();
    n_cmp++;
    if (if1.p !== 32'h00001234) begin
      n_fail++;
      $display("FAIL bypass_pos: got p=%h want p=00001234", if1.p);
    end
    if1.a = 16'hFFFB; if1.b = 16'h0007;
    tick();
    n_cmp++;
    if (if1.p !== 32'hFFFFFFFB) begin
      n_fail++;
      $display("FAIL bypass_neg: got p=%h want p=fffffffb", if1.p);
    end
    if1.bypass = 1'b0; if1.a = 16'd3; if1.b = 16'd5;
    tick();
    n_cmp++;
    if (if1.p !== 32'd15) begin
      n_fail++;
      $display("FAIL bypass_off: got p=%h want p=0000000f", if1.p);
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst    = 1'b1;
    if16.en = 1'b0; if16.in_valid = 1'b0; if16.a = '0; if16.b = '0;
    if24.en = 1'b0; if24.in_valid = 1'b0; if24.a = '0; if24.b = '0;
    if1.en  = 1'b0; if1.in_valid  = 1'b0; if1.a  = '0; if1.b  = '0;
    ifu.en  = 1'b0; ifu.in_valid  = 1'b0; ifu.a  = '0; ifu.b  = '0;
`ifdef PIPE_MULT_DELAY_BYPASS_EN
    if16.bypass = 1'b0; if24.bypass = 1'b0; if1.bypass = 1'b0; ifu.bypass = 1'b0;
`endif
    test_reset();
    test_basic();
    test_corners();
    test_wide();
    test_reset_midstream();
    test_stall();
    test_latency1();
    test_unsigned();
`ifdef PIPE_MULT_DELAY_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
